// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: DataMem op encodings and FSM state constants.
package lsu_pkg;

    localparam logic [2:0] M_LB  = 3'd0;
    localparam logic [2:0] M_LH  = 3'd1;
    localparam logic [2:0] M_LW  = 3'd2;
    localparam logic [2:0] M_LBU = 3'd4;
    localparam logic [2:0] M_LHU = 3'd5;

    // Stores reuse the load encodings; DataMem sizes the write from memOp[1:0].
    localparam logic [2:0] M_SB  = M_LB;
    localparam logic [2:0] M_SH  = M_LH;
    localparam logic [2:0] M_SW  = M_LW;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t S_IDLE    = 2'd0;
    localparam lsu_state_t S_ACCESS  = 2'd1;
    localparam lsu_state_t S_CAPTURE = 2'd2;
    localparam lsu_state_t S_RESP    = 2'd3;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check of an incoming request: bad opcodes, misalignment and
// unsigned-store encodings all fault.
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] mem_op,
    input  logic       we,
    output logic       fault
);

    always_comb begin
        fault = 1'b0;
        case (mem_op)
            M_LB, M_LBU: fault = 1'b0;
            M_LH, M_LHU: fault = addr[0];
            M_LW:        fault = |addr;
            default:     fault = 1'b1;
        endcase
        if (we && (mem_op == M_LBU || mem_op == M_LHU)) begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, drives DataMem from latched registers and
// returns exactly one data or fault response, with saturating completion counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    input  logic [2:0]        reqMemOp,
    input  logic              reqWe,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspRdata,
    output logic              rspFault,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDin,
    output logic [2:0]        memOp,
    output logic              memWe,
    input  logic [DATA_W-1:0] memDout,
    output logic [CNT_W-1:0]  loadCnt,
    output logic [CNT_W-1:0]  storeCnt,
    output logic [CNT_W-1:0]  faultCnt
);

    lsu_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        op_q;
    logic              we_q;
    logic              fault_q;
    logic              req_fault;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  fault_cnt;

    lsu_align_check u_align_check (
        .addr   (reqAddr[1:0]),
        .mem_op (reqMemOp),
        .we     (reqWe),
        .fault  (req_fault)
    );

    assign reqReady = (state == S_IDLE) && !rst;
    assign rspValid = (state == S_RESP);
    assign rspFault = (state == S_RESP) && fault_q;
    assign rspRdata = rdata_q;
    assign memAddr  = addr_q;
    assign memDin   = wdata_q;
    assign memOp    = op_q;
    // Gate on rst so an asynchronous reset during ACCESS cannot commit a write.
    assign memWe    = (state == S_ACCESS) && we_q && !rst;
    assign loadCnt  = load_cnt;
    assign storeCnt = store_cnt;
    assign faultCnt = fault_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            op_q      <= '0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (reqValid) begin
                        addr_q  <= reqAddr;
                        wdata_q <= reqWdata;
                        op_q    <= reqMemOp;
                        we_q    <= reqWe;
                        fault_q <= req_fault;
                        rdata_q <= '0;
                        state   <= req_fault ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state <= we_q ? S_RESP : S_CAPTURE;
                end
                S_CAPTURE: begin
                    rdata_q <= memDout;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (rspReady) begin
                        state <= S_IDLE;
                        if (fault_q) begin
                            if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
                        end else if (we_q) begin
                            if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
                        end else begin
                            if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-array DataMem model
// and a byte-level reference model of expected responses, latencies and counters.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqMemOp;
    logic        reqWe;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspFault;
    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic [2:0]  memOp;
    logic        memWe;
    logic [31:0] memDout;
    logic [15:0] loadCnt;
    logic [15:0] storeCnt;
    logic [15:0] faultCnt;

    // Second instance with narrow counters to reach saturation quickly
    logic        s_reqValid;
    logic        s_reqReady;
    logic [31:0] s_reqAddr;
    logic [31:0] s_reqWdata;
    logic [2:0]  s_reqMemOp;
    logic        s_reqWe;
    logic        s_rspValid;
    logic        s_rspReady;
    logic [31:0] s_rspRdata;
    logic        s_rspFault;
    logic [31:0] s_memAddr;
    logic [31:0] s_memDin;
    logic [2:0]  s_memOp;
    logic        s_memWe;
    logic [31:0] s_memDout;
    logic [1:0]  s_loadCnt;
    logic [1:0]  s_storeCnt;
    logic [1:0]  s_faultCnt;

    int cmp_cnt;
    int err_cnt;
    int n_load;
    int n_store;
    int n_fault;
    logic [31:0] last_rdata;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [31:0] bd_data;
    logic [9:0] ma;
    logic [9:0] bb;

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqWdata(reqWdata), .reqMemOp(reqMemOp), .reqWe(reqWe), .rspValid(rspValid),
        .rspReady(rspReady), .rspRdata(rspRdata), .rspFault(rspFault), .memAddr(memAddr),
        .memDin(memDin), .memOp(memOp), .memWe(memWe), .memDout(memDout),
        .loadCnt(loadCnt), .storeCnt(storeCnt), .faultCnt(faultCnt)
    );

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .reqValid(s_reqValid), .reqReady(s_reqReady),
        .reqAddr(s_reqAddr), .reqWdata(s_reqWdata), .reqMemOp(s_reqMemOp), .reqWe(s_reqWe),
        .rspValid(s_rspValid), .rspReady(s_rspReady), .rspRdata(s_rspRdata),
        .rspFault(s_rspFault), .memAddr(s_memAddr), .memDin(s_memDin), .memOp(s_memOp),
        .memWe(s_memWe), .memDout(s_memDout), .loadCnt(s_loadCnt), .storeCnt(s_storeCnt),
        .faultCnt(s_faultCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ma = memAddr[9:0];
    assign bb = {bd_addr, 2'b00};
    assign s_memDout = 32'h0;

    // DataMem model: little-endian byte array, combinational read, write on the clock edge
    always @(posedge clk) begin
        if (memWe) begin
            mem[ma] <= memDin[7:0];
            if (memOp[1:0] != 2'd0) mem[ma + 10'd1] <= memDin[15:8];
            if (memOp[1:0] == 2'd2) begin
                mem[ma + 10'd2] <= memDin[23:16];
                mem[ma + 10'd3] <= memDin[31:24];
            end
        end
        if (bd_we) begin
            mem[bb]         <= bd_data[7:0];
            mem[bb + 10'd1] <= bd_data[15:8];
            mem[bb + 10'd2] <= bd_data[23:16];
            mem[bb + 10'd3] <= bd_data[31:24];
        end
    end

    always_comb begin
        memDout = 32'h0;
        case (memOp)
            3'd0: memDout = {{24{mem[ma][7]}}, mem[ma]};
            3'd1: memDout = {{16{mem[ma + 10'd1][7]}}, mem[ma + 10'd1], mem[ma]};
            3'd2: memDout = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
            3'd4: memDout = {24'h0, mem[ma]};
            3'd5: memDout = {16'h0, mem[ma + 10'd1], mem[ma]};
            default: memDout = 32'h0;
        endcase
    end

    function automatic logic ref_fault(input logic [31:0] a, input logic [2:0] op,
                                       input logic we);
        if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b1;
        if (op == 3'd2 && a[1:0] != 2'd0) return 1'b1;
        if ((op == 3'd1 || op == 3'd5) && a[0]) return 1'b1;
        if (we && (op == 3'd4 || op == 3'd5)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int op_bytes(input logic [2:0] op);
        if (op[1:0] == 2'd0) return 1;
        if (op[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
        int          nb;
        logic [31:0] v;
        nb = op_bytes(op);
        v  = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(a + i) & 1023]) << (8 * i));
        if (!op[2] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    task automatic bd_write(input logic [7:0] widx, input logic [31:0] data);
        for (int i = 0; i < 4; i++) ref_mem[{widx, 2'b00} + i] = data[8 * i +: 8];
        bd_we   = 1'b1;
        bd_addr = widx;
        bd_data = data;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    // One full transaction with latency, memory-side, response and counter checks
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                       input logic we, input int hold);
        logic        exp_f;
        logic [31:0] exp_d;
        int          exp_lat;
        int          exp_we;
        int          lat;
        int          we_cyc;
        int          k;
        logic        bad_mem;
        logic        busy_bad;
        logic        stall_bad;
        exp_f   = ref_fault(a, op, we);
        exp_lat = exp_f ? 1 : (we ? 2 : 3);
        exp_we  = (we && !exp_f) ? 1 : 0;
        exp_d   = (!exp_f && !we) ? ref_load(a, op) : 32'h0;
        k = 0;
        while (!reqReady && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        cmp_cnt++;
        if (reqReady !== 1'b1) begin
            err_cnt++;
            $display("FAIL req_ready_wait: reqReady=%b required 1", reqReady);
        end
        reqValid  = 1'b1;
        reqAddr   = a;
        reqWdata  = d;
        reqMemOp  = op;
        reqWe     = we;
        rspReady  = (hold == 0);
        @(posedge clk); #1;
        reqValid  = 1'b0;
        reqAddr   = $urandom;
        reqWdata  = $urandom;
        reqMemOp  = 3'($urandom_range(0, 7));
        reqWe     = 1'($urandom_range(0, 1));
        lat       = 0;
        we_cyc    = 0;
        bad_mem   = 1'b0;
        busy_bad  = 1'b0;
        stall_bad = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (reqReady !== 1'b0) busy_bad = 1'b1;
            if (memWe === 1'b1) begin
                we_cyc++;
                if (memAddr !== a || memOp !== op || memDin !== d) bad_mem = 1'b1;
            end
            if (rspValid === 1'b1) lat = c;
            else begin
                @(posedge clk); #1;
            end
        end
        last_rdata = rspRdata;
        cmp_cnt++;
        if (lat !== exp_lat) begin
            err_cnt++;
            $display("FAIL latency a=%h op=%0d we=%b: got %0d required %0d", a, op, we, lat,
                     exp_lat);
        end
        cmp_cnt++;
        if (rspFault !== exp_f || rspRdata !== exp_d) begin
            err_cnt++;
            $display("FAIL response a=%h op=%0d we=%b: fault=%b data=%h required %b %h", a, op,
                     we, rspFault, rspRdata, exp_f, exp_d);
        end
        cmp_cnt++;
        if (we_cyc !== exp_we || bad_mem) begin
            err_cnt++;
            $display("FAIL mem_write a=%h op=%0d: we cycles %0d required %0d, bad drive %b", a,
                     op, we_cyc, exp_we, bad_mem);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (rspValid !== 1'b1 || rspRdata !== exp_d || rspFault !== exp_f ||
                reqReady !== 1'b0) stall_bad = 1'b1;
        end
        cmp_cnt++;
        if (busy_bad || stall_bad) begin
            err_cnt++;
            $display("FAIL busy_stable: busy=%b stall=%b required 0 0", busy_bad, stall_bad);
        end
        rspReady = 1'b1;
        if (exp_f) n_fault++;
        else if (we) begin
            n_store++;
            for (int i = 0; i < op_bytes(op); i++) ref_mem[(a + i) & 1023] = d[8 * i +: 8];
        end else n_load++;
        @(posedge clk); #1;
        cmp_cnt++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            err_cnt++;
            $display("FAIL return_idle: rspValid=%b reqReady=%b required 0 1", rspValid,
                     reqReady);
        end
        cmp_cnt++;
        if (loadCnt !== sat16(n_load) || storeCnt !== sat16(n_store) ||
            faultCnt !== sat16(n_fault)) begin
            err_cnt++;
            $display("FAIL counters: %0d/%0d/%0d required %0d/%0d/%0d", loadCnt, storeCnt,
                     faultCnt, n_load, n_store, n_fault);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp_cnt++;
        if (reqReady !== 1'b0 || memWe !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_gating: reqReady=%b memWe=%b required 0 0", reqReady, memWe);
        end
        for (int w = 0; w < 256; w++) bd_write(8'(w), $urandom);
        rst = 1'b0;
        @(posedge clk); #1;
        cmp_cnt++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0 || rspFault !== 1'b0 ||
            rspRdata !== 32'h0 || memAddr !== 32'h0 || memWe !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: rdy=%b vld=%b flt=%b rd=%h addr=%h we=%b", reqReady,
                     rspValid, rspFault, rspRdata, memAddr, memWe);
        end
        cmp_cnt++;
        if (loadCnt !== 16'h0 || storeCnt !== 16'h0 || faultCnt !== 16'h0) begin
            err_cnt++;
            $display("FAIL reset_counters: %h %h %h required 0 0 0", loadCnt, storeCnt,
                     faultCnt);
        end
    endtask

    task automatic test_directed;
        bd_write(8'h40, 32'hDEAD_BEEF);
        txn(32'h100, 32'h0, 3'd2, 1'b0, 0);
        cmp_cnt++;
        if (last_rdata !== 32'hDEAD_BEEF) begin
            err_cnt++;
            $display("FAIL lw_value: got %h required deadbeef", last_rdata);
        end
        txn(32'h203, 32'h1234_56AB, 3'd0, 1'b1, 0);
        txn(32'h203, 32'h0, 3'd4, 1'b0, 0);
        cmp_cnt++;
        if (last_rdata !== 32'h0000_00AB) begin
            err_cnt++;
            $display("FAIL lbu_value: got %h required 000000ab", last_rdata);
        end
        txn(32'h203, 32'h0, 3'd0, 1'b0, 0);
        cmp_cnt++;
        if (last_rdata !== 32'hFFFF_FFAB) begin
            err_cnt++;
            $display("FAIL lb_value: got %h required ffffffab", last_rdata);
        end
    endtask

    task automatic test_faults;
        txn(32'h102, 32'h0, 3'd2, 1'b0, 0);
        txn(32'h101, 32'h0, 3'd1, 1'b0, 0);
        txn(32'h104, 32'h5555_AAAA, 3'd5, 1'b1, 0);
        txn(32'h108, 32'h0, 3'd3, 1'b0, 0);
    endtask

    task automatic test_stall;
        txn(32'h100, 32'h0, 3'd2, 1'b0, 5);
        txn(32'h204, 32'hCAFE_F00D, 3'd2, 1'b1, 3);
        txn(32'h105, 32'h0, 3'd6, 1'b0, 2);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            txn(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        reqValid = 1'b1;
        reqAddr  = 32'h300;
        reqWdata = $urandom;
        reqMemOp = 3'd2;
        reqWe    = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        cmp_cnt++;
        if (memWe !== 1'b1) begin
            err_cnt++;
            $display("FAIL access_we: memWe=%b required 1", memWe);
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if (memWe !== 1'b0 || rspValid !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset_we: memWe=%b rspValid=%b required 0 0", memWe, rspValid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_load = 0;
        n_store = 0;
        n_fault = 0;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rspValid !== 1'b0 || reqReady !== 1'b1) bad = 1'b1;
        end
        cmp_cnt++;
        if (bad) begin
            err_cnt++;
            $display("FAIL abort_no_response: response or busy seen, required idle");
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (mem[10'h300 + 10'(i)] !== ref_mem[32'h300 + i]) bad = 1'b1;
        cmp_cnt++;
        if (bad || loadCnt !== 16'h0 || storeCnt !== 16'h0 || faultCnt !== 16'h0) begin
            err_cnt++;
            $display("FAIL abort_state: mem changed=%b counters %h %h %h required 0", bad,
                     loadCnt, storeCnt, faultCnt);
        end
        txn(32'h300, 32'h0, 3'd2, 1'b0, 0);
    endtask

    task automatic test_saturate;
        int k;
        s_rspReady = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            k = 0;
            while (!s_reqReady && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            s_reqValid = 1'b1;
            s_reqAddr  = 32'h1;
            s_reqMemOp = 3'd2;
            s_reqWe    = 1'b0;
            @(posedge clk); #1;
            s_reqValid = 1'b0;
            @(posedge clk); #1;
            cmp_cnt++;
            if (s_faultCnt !== ((n > 3) ? 2'd3 : 2'(n)) || s_loadCnt !== 2'd0 ||
                s_storeCnt !== 2'd0) begin
                err_cnt++;
                $display("FAIL fault_saturate n=%0d: fault=%0d load=%0d store=%0d", n,
                         s_faultCnt, s_loadCnt, s_storeCnt);
            end
        end
        s_reqValid = 1'b1;
        s_reqAddr  = 32'h0;
        s_reqMemOp = 3'd2;
        @(posedge clk); #1;
        s_reqValid = 1'b0;
        k = 0;
        while (!s_rspValid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        cmp_cnt++;
        if (s_loadCnt !== 2'd1 || s_faultCnt !== 2'd3) begin
            err_cnt++;
            $display("FAIL sat_others: load=%0d fault=%0d required 1 3", s_loadCnt, s_faultCnt);
        end
    endtask

    initial begin
        cmp_cnt    = 0;
        err_cnt    = 0;
        n_load     = 0;
        n_store    = 0;
        n_fault    = 0;
        last_rdata = 32'h0;
        rst        = 1'b1;
        reqValid   = 1'b0;
        reqAddr    = 32'h0;
        reqWdata   = 32'h0;
        reqMemOp   = 3'd0;
        reqWe      = 1'b0;
        rspReady   = 1'b1;
        bd_we      = 1'b0;
        bd_addr    = 8'h0;
        bd_data    = 32'h0;
        s_reqValid = 1'b0;
        s_reqAddr  = 32'h0;
        s_reqWdata = 32'h0;
        s_reqMemOp = 3'd0;
        s_reqWe    = 1'b0;
        s_rspReady = 1'b1;
        test_reset;
        test_directed;
        test_faults;
        test_stall;
        test_random;
        test_reset_mid;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
